// File: rtl/spi_tx_pkg.sv
// Shared types for the SPI display transmitter: FIFO entry layout and FSM state encoding.
// Imported by the FIFO and the top level so both agree on the entry format.
package spi_tx_pkg;

    typedef struct packed {
        logic       last;
        logic       dc;
        logic [7:0] data;
    } spi_tx_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_SHIFT_LO = 3'd3,
        ST_STALL    = 3'd4,
        ST_HOLD     = 3'd5,
        ST_GAP      = 3'd6
    } spi_tx_state_t;

    localparam int ENTRY_W = $bits(spi_tx_entry_t);

endpackage

// File: rtl/spi_tx_fifo.sv
// Generic synchronous FIFO of spi_tx_entry_t; read data is the combinational head entry.
// Latency: a pushed entry is visible at the head one cycle later; push ignored when full.
module spi_tx_fifo
    import spi_tx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push_i,
    input  spi_tx_entry_t            wr_data_i,
    input  logic                     pop_i,
    output spi_tx_entry_t            rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    spi_tx_entry_t mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (count_o == (AW+1)'(DEPTH));
    assign empty_o = (wr_ptr_q == rd_ptr_q);

    assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/spi_lcd_tx.sv
// SPI mode-0 master that serialises buffered command/data bytes MSB-first with dc and csn framing.
// Bytes in a frame stream back-to-back while the FIFO keeps up; tx_ready drops when the FIFO is full.
module spi_lcd_tx
    import spi_tx_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CS_GAP     = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_dc,
    input  logic       tx_last,
    output logic       busy,
    output logic       spi_sclk,
    output logic       spi_sdo,
    output logic       dc,
    output logic       csn
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int GAP_W = $clog2(CS_GAP + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(CS_GAP - 1);

    spi_tx_state_t    state_q;
    logic [DIV_W-1:0] div_q;
    logic [2:0]       bit_q;
    logic [GAP_W-1:0] gap_q;
    logic [6:0]       shift_q;
    logic             last_q;
    logic             sclk_q;
    logic             sdo_q;
    logic             dc_q;
    logic             csn_q;

    spi_tx_entry_t    wr_entry;
    spi_tx_entry_t    head;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             div_done;
    logic             byte_end;

    assign wr_entry  = '{last: tx_last, dc: tx_dc, data: tx_data};
    assign tx_ready  = !fifo_full;
    assign fifo_push = tx_valid && tx_ready;

    spi_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push_i    (fifo_push),
        .wr_data_i (wr_entry),
        .pop_i     (fifo_pop),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign div_done = (div_q == '0);
    // The 8th falling edge of a byte: the point where the frame continues, stalls or closes.
    assign byte_end = (state_q == ST_SHIFT_HI) && div_done && (bit_q == 3'd7);

    always_comb begin
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE,
            ST_STALL:    fifo_pop = !fifo_empty;
            ST_SHIFT_HI: fifo_pop = byte_end && !last_q && !fifo_empty;
            default:     fifo_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            shift_q <= '0;
            last_q  <= 1'b0;
            sclk_q  <= 1'b0;
            sdo_q   <= 1'b0;
            dc_q    <= 1'b0;
            csn_q   <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        shift_q <= head.data[6:0];
                        sdo_q   <= head.data[7];
                        dc_q    <= head.dc;
                        last_q  <= head.last;
                        csn_q   <= 1'b0;
                        sclk_q  <= 1'b0;
                        bit_q   <= '0;
                        div_q   <= DIV_RELOAD;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (div_done) begin
                        sclk_q  <= 1'b1;
                        div_q   <= DIV_RELOAD;
                        state_q <= ST_SHIFT_HI;
                    end else begin
                        div_q <= div_q - 1'b1;
                    end
                end
                ST_SHIFT_HI: begin
                    if (div_done) begin
                        sclk_q <= 1'b0;
                        bit_q  <= bit_q + 1'b1;
                        div_q  <= DIV_RELOAD;
                        if (bit_q == 3'd7) begin
                            if (last_q) begin
                                state_q <= ST_HOLD;
                            end else if (!fifo_empty) begin
                                // Next byte of the same frame: first bit goes out on this fall.
                                shift_q <= head.data[6:0];
                                sdo_q   <= head.data[7];
                                dc_q    <= head.dc;
                                last_q  <= head.last;
                                state_q <= ST_SHIFT_LO;
                            end else begin
                                state_q <= ST_STALL;
                            end
                        end else begin
                            sdo_q   <= shift_q[6];
                            shift_q <= {shift_q[5:0], 1'b0};
                            state_q <= ST_SHIFT_LO;
                        end
                    end else begin
                        div_q <= div_q - 1'b1;
                    end
                end
                ST_SHIFT_LO: begin
                    if (div_done) begin
                        sclk_q  <= 1'b1;
                        div_q   <= DIV_RELOAD;
                        state_q <= ST_SHIFT_HI;
                    end else begin
                        div_q <= div_q - 1'b1;
                    end
                end
                ST_STALL: begin
                    if (!fifo_empty) begin
                        shift_q <= head.data[6:0];
                        sdo_q   <= head.data[7];
                        dc_q    <= head.dc;
                        last_q  <= head.last;
                        div_q   <= DIV_RELOAD;
                        state_q <= ST_LOAD;
                    end
                end
                ST_HOLD: begin
                    if (div_done) begin
                        csn_q   <= 1'b1;
                        gap_q   <= GAP_RELOAD;
                        state_q <= ST_GAP;
                    end else begin
                        div_q <= div_q - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy     = (fifo_count != '0) || (state_q != ST_IDLE);
    assign spi_sclk = sclk_q;
    assign spi_sdo  = sdo_q;
    assign dc       = dc_q;
    assign csn      = csn_q;

endmodule
